cs_sample_assembler: RTL and testbench



---
 rtl/cs_sample_assembler.sv | 183 ++++++++++++++++++
 tb/tb_cs_sample_assembler.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cs_sample_assembler.sv
// Packs MSB-first bytes from the SPI receiver into SAMPLE_W-bit samples and buffers one frame.
// Optional frame checksum byte and CHECK state are enabled with `define CS_FRAME_CHECKSUM_EN.
module cs_sample_assembler #(
    parameter int NUM_SAMPLES = 64,
    parameter int SAMPLE_W    = 16,
    parameter int ADDR_W      = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                byte_valid,
    input  logic [7:0]          byte_data,
    input  logic                frame_clr,
    input  logic                frame_ack,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [SAMPLE_W-1:0] rd_data,
    output logic                frame_ready,
    output logic [ADDR_W:0]     fill_count,
`ifdef CS_FRAME_CHECKSUM_EN
    output logic                checksum_err,
`endif
    output logic                overflow_err
);

    localparam int BYTES_PER_SAMPLE = SAMPLE_W / 8;
    localparam int PH_W = (BYTES_PER_SAMPLE > 1) ? $clog2(BYTES_PER_SAMPLE) : 1;
    localparam logic [PH_W-1:0]  LAST_PHASE = PH_W'(BYTES_PER_SAMPLE - 1);
    localparam logic [ADDR_W:0]  LAST_IDX   = (ADDR_W + 1)'(NUM_SAMPLES - 1);

`ifdef CS_FRAME_CHECKSUM_EN
    typedef enum logic [1:0] {ST_FILL, ST_READY, ST_CHECK} state_t;
`else
    typedef enum logic [1:0] {ST_FILL, ST_READY} state_t;
`endif

    state_t                state_q, state_d;
    logic [PH_W-1:0]       phase_q, phase_d;
    logic [ADDR_W:0]       fill_q, fill_d;
    logic [SAMPLE_W-1:0]   shift_q, shift_d;
    logic                  ovf_q, ovf_d;
    logic                  mem_we;
    logic [SAMPLE_W-1:0]   word;
`ifdef CS_FRAME_CHECKSUM_EN
    logic [7:0]            xor_q, xor_d;
    logic                  cerr_q, cerr_d;
`endif

    logic [SAMPLE_W-1:0]   mem [0:NUM_SAMPLES-1];

    // Word as it would look after shifting in the current byte.
    generate
        if (BYTES_PER_SAMPLE == 1) begin : g_single
            assign word = byte_data;
        end else begin : g_multi
            assign word = {shift_q[SAMPLE_W-9:0], byte_data};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        fill_d  = fill_q;
        shift_d = shift_q;
        ovf_d   = ovf_q;
        mem_we  = 1'b0;
`ifdef CS_FRAME_CHECKSUM_EN
        xor_d   = xor_q;
        cerr_d  = cerr_q;
`endif
        if (frame_clr) begin
            state_d = ST_FILL;
            phase_d = '0;
            fill_d  = '0;
            ovf_d   = 1'b0;
`ifdef CS_FRAME_CHECKSUM_EN
            xor_d   = '0;
            cerr_d  = 1'b0;
`endif
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (byte_valid) begin
                        shift_d = word;
`ifdef CS_FRAME_CHECKSUM_EN
                        xor_d   = xor_q ^ byte_data;
`endif
                        if (phase_q == LAST_PHASE) begin
                            mem_we  = 1'b1;
                            phase_d = '0;
                            fill_d  = fill_q + (ADDR_W + 1)'(1);
                            if (fill_q == LAST_IDX) begin
`ifdef CS_FRAME_CHECKSUM_EN
                                state_d = ST_CHECK;
`else
                                state_d = ST_READY;
`endif
                            end
                        end else begin
                            phase_d = phase_q + PH_W'(1);
                        end
                    end
                end
                ST_READY: begin
                    if (byte_valid) begin
                        ovf_d = 1'b1;
                    end
                    if (frame_ack) begin
                        state_d = ST_FILL;
                        phase_d = '0;
                        fill_d  = '0;
`ifdef CS_FRAME_CHECKSUM_EN
                        xor_d   = '0;
`endif
                    end
                end
`ifdef CS_FRAME_CHECKSUM_EN
                ST_CHECK: begin
                    if (byte_valid) begin
                        if (byte_data == xor_q) begin
                            state_d = ST_READY;
                            cerr_d  = 1'b0;
                        end else begin
                            // Corrupt frame is discarded; the buffer is never offered.
                            state_d = ST_FILL;
                            cerr_d  = 1'b1;
                            phase_d = '0;
                            fill_d  = '0;
                            xor_d   = '0;
                        end
                    end
                end
`endif
                default: state_d = ST_FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
            phase_q <= '0;
            fill_q  <= '0;
            shift_q <= '0;
            ovf_q   <= 1'b0;
`ifdef CS_FRAME_CHECKSUM_EN
            xor_q   <= '0;
            cerr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            fill_q  <= fill_d;
            shift_q <= shift_d;
            ovf_q   <= ovf_d;
`ifdef CS_FRAME_CHECKSUM_EN
            xor_q   <= xor_d;
            cerr_q  <= cerr_d;
`endif
        end
    end

    // Frame buffer carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[fill_q[ADDR_W-1:0]] <= word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

    assign frame_ready  = (state_q == ST_READY);
    assign fill_count   = fill_q;
    assign overflow_err = ovf_q;
`ifdef CS_FRAME_CHECKSUM_EN
    assign checksum_err = cerr_q;
`endif

endmodule

// File: tb/tb_cs_sample_assembler.sv
// Scoreboard bench for cs_sample_assembler with a 4-sample, 16-bit frame.
// Build with +define+CS_FRAME_CHECKSUM_EN to cover the checksum variant as well.
module tb_cs_sample_assembler;

    localparam int N  = 4;
    localparam int SW = 16;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          frame_clr;
    logic          frame_ack;
    logic [AW-1:0] rd_addr;
    logic [SW-1:0] rd_data;
    logic          frame_ready;
    logic [AW:0]   fill_count;
    logic          overflow_err;
`ifdef CS_FRAME_CHECKSUM_EN
    logic          checksum_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [SW-1:0] sb_q [$];

    cs_sample_assembler #(.NUM_SAMPLES(N), .SAMPLE_W(SW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .frame_clr    (frame_clr),
        .frame_ack    (frame_ack),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .frame_ready  (frame_ready),
        .fill_count   (fill_count),
`ifdef CS_FRAME_CHECKSUM_EN
        .checksum_err (checksum_err),
`endif
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_valid = 1'b1;
        byte_data  = b;
        tick();
        byte_valid = 1'b0;
        $display("txn byte 0x%02h -> ready=%0d fill=%0d ovf=%0d", b, frame_ready, fill_count, overflow_err);
    endtask

    task automatic read_check(input string tag, input logic [AW-1:0] a, input logic [SW-1:0] exp);
        sb_q.push_back(exp);
        rd_addr = a;
        tick();
        $display("txn read addr %0d -> 0x%04h", a, rd_data);
        if (sb_q.size() == 0) begin
            check_value({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            check_value(tag, 32'(rd_data), 32'(sb_q.pop_front()));
        end
    endtask

    // Sends 2*N bytes; with the checksum feature the bench-computed XOR follows.
    task automatic send_frame(input string tag, input logic [7:0] b [2*N]);
        logic [7:0] cks;
        cks = 8'h00;
        for (int i = 0; i < 2 * N; i++) begin
            send_byte(b[i]);
            cks = cks ^ b[i];
            if (i == 2 * N - 2) check_value({tag, "_ready_early"}, 32'(frame_ready), 32'd0);
        end
`ifdef CS_FRAME_CHECKSUM_EN
        check_value({tag, "_ready_in_check"}, 32'(frame_ready), 32'd0);
        send_byte(cks);
        check_value({tag, "_cks_err"}, 32'(checksum_err), 32'd0);
`endif
        check_value({tag, "_ready"}, 32'(frame_ready), 32'd1);
        check_value({tag, "_fill"}, 32'(fill_count), 32'(N));
    endtask

    logic [7:0] frame_a [2*N];
    logic [7:0] frame_b [2*N];

    initial begin
        frame_a = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'hFF, 8'hFE};
        frame_b = '{8'hA5, 8'h5A, 8'h00, 8'hFF, 8'h80, 8'h01, 8'h7F, 8'hFE};
        rst_n = 1'b0; byte_valid = 1'b0; byte_data = '0;
        frame_clr = 1'b0; frame_ack = 1'b0; rd_addr = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check_value("rst_ready", 32'(frame_ready), 32'd0);
        check_value("rst_fill", 32'(fill_count), 32'd0);
        check_value("rst_ovf", 32'(overflow_err), 32'd0);
`ifdef CS_FRAME_CHECKSUM_EN
        check_value("rst_cks_err", 32'(checksum_err), 32'd0);
`endif

        // Full frame, then read back
        send_frame("frame_a", frame_a);
        read_check("rd0", 2'd0, 16'h1234);
        read_check("rd1", 2'd1, 16'hABCD);
        read_check("rd2", 2'd2, 16'h0001);
        read_check("rd3", 2'd3, 16'hFFFE);

        // Byte while frozen
        send_byte(8'h55);
        check_value("ovf_set", 32'(overflow_err), 32'd1);
        check_value("ovf_still_ready", 32'(frame_ready), 32'd1);
        read_check("ovf_rd0", 2'd0, 16'h1234);
        read_check("ovf_rd3", 2'd3, 16'hFFFE);
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        check_value("ack_ready", 32'(frame_ready), 32'd0);
        check_value("ack_fill", 32'(fill_count), 32'd0);
        check_value("ack_ovf_sticky", 32'(overflow_err), 32'd1);

        // Partial byte discarded by frame_clr
        send_byte(8'h12);
        frame_clr = 1'b1;
        tick();
        frame_clr = 1'b0;
        check_value("clr_ovf", 32'(overflow_err), 32'd0);
        send_byte(8'h56);
        send_byte(8'h78);
        check_value("clr_fill", 32'(fill_count), 32'd1);
        read_check("clr_rd0", 2'd0, 16'h5678);

        // frame_ack in FILL ignored; frame_clr beats a same-cycle byte
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        check_value("ack_in_fill", 32'(fill_count), 32'd1);
        send_byte(8'h11);
        byte_valid = 1'b1; byte_data = 8'h99; frame_clr = 1'b1;
        tick();
        byte_valid = 1'b0; frame_clr = 1'b0;
        check_value("clr_byte_fill", 32'(fill_count), 32'd0);
        read_check("clr_byte_rd1", 2'd1, 16'hABCD);
        read_check("clr_byte_rd0", 2'd0, 16'h5678);
        send_byte(8'h22);
        send_byte(8'h33);
        check_value("phase0_fill", 32'(fill_count), 32'd1);
        read_check("phase0_rd0", 2'd0, 16'h2233);

        // Asynchronous reset mid-frame
        send_byte(8'h44);
        send_byte(8'h55);
        send_byte(8'h66);
        check_value("pre_rst_fill", 32'(fill_count), 32'd2);
        #3;
        rst_n = 1'b0;
        #1;
        check_value("arst_fill", 32'(fill_count), 32'd0);
        check_value("arst_ready", 32'(frame_ready), 32'd0);
        check_value("arst_ovf", 32'(overflow_err), 32'd0);
        check_value("arst_rd", 32'(rd_data), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        send_frame("frame_b", frame_b);
        read_check("b_rd0", 2'd0, 16'hA55A);
        read_check("b_rd1", 2'd1, 16'h00FF);
        read_check("b_rd2", 2'd2, 16'h8001);
        read_check("b_rd3", 2'd3, 16'h7FFE);

`ifdef CS_FRAME_CHECKSUM_EN
        // Bad checksum (frame_a XOR is 0x40, so 0x00 mismatches)
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        for (int i = 0; i < 2 * N; i++) send_byte(frame_a[i]);
        send_byte(8'h00);
        check_value("badcks_err", 32'(checksum_err), 32'd1);
        check_value("badcks_ready", 32'(frame_ready), 32'd0);
        check_value("badcks_fill", 32'(fill_count), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
